// File: rtl/dp_feed_ctrl_pkg.sv
// rtl/dp_feed_ctrl_pkg.sv - shared widths and types for the DP feed sequencer
package dp_feed_ctrl_pkg;

    localparam int N             = 8;
    localparam int LOG_N         = 3;
    localparam int BP_WIDTH      = 4;
    localparam int CALC_WIDTH    = 8;
    localparam int ADDRESS_WIDTH = 6;

    // Shared by query and reference phases, so it must cover the wider length.
    localparam int CNT_WIDTH = (LOG_N > ADDRESS_WIDTH) ? LOG_N : ADDRESS_WIDTH;

    typedef struct packed {
        logic [LOG_N-1:0]         qlen;
        logic [ADDRESS_WIDTH-1:0] rlen;
    } feed_cmd_t;

endpackage

// File: rtl/dp_feed_ctrl_if.sv
// rtl/dp_feed_ctrl_if.sv - host streams, DP control and result handshake bundle
interface dp_feed_ctrl_if;
    import dp_feed_ctrl_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [LOG_N-1:0]         cmd_qlen;
    logic [ADDRESS_WIDTH-1:0] cmd_rlen;

    logic [BP_WIDTH-1:0]      q_data;
    logic                     q_valid;
    logic                     q_ready;
    logic [BP_WIDTH-1:0]      r_data;
    logic                     r_valid;
    logic                     r_ready;

    logic                     abort;

    logic [BP_WIDTH-1:0]      S;
    logic [BP_WIDTH-1:0]      T;
    logic                     s_update;
    logic                     valid;
    logic                     new_seq;
    logic [LOG_N-1:0]         PE_end;
    logic                     busy;
    logic [CALC_WIDTH-1:0]    max_o;
    logic                     ack;

    logic [CALC_WIDTH-1:0]    score;
    logic                     score_valid;
    logic                     score_ready;

    modport master (
        input  cmd_valid, cmd_qlen, cmd_rlen,
        input  q_data, q_valid, r_data, r_valid, abort,
        input  busy, max_o, score_ready,
        output cmd_ready, q_ready, r_ready,
        output S, T, s_update, valid, new_seq, PE_end, ack,
        output score, score_valid
    );

    modport slave (
        output cmd_valid, cmd_qlen, cmd_rlen,
        output q_data, q_valid, r_data, r_valid, abort,
        output busy, max_o, score_ready,
        input  cmd_ready, q_ready, r_ready,
        input  S, T, s_update, valid, new_seq, PE_end, ack,
        input  score, score_valid
    );

endinterface

// File: rtl/dp_feed_ctrl_feed_counter.sv
// rtl/dp_feed_ctrl_feed_counter.sv - loadable up/down counter with terminal-equality flag
module feed_counter
    import dp_feed_ctrl_pkg::*;
#(
    parameter int W = CNT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic [W-1:0] cmp_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == cmp_i);

endmodule

// File: rtl/dp_feed_ctrl.sv
// rtl/dp_feed_ctrl.sv - sequences query load, reference stream, drain and result hand-off for one DP engine
module dp_feed_ctrl
    import dp_feed_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset_i,
    dp_feed_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_S   = 3'd1,
        STREAM_T = 3'd2,
        DRAIN    = 3'd3,
        SEQ_END  = 3'd4,
        RESULT   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    feed_cmd_t             cmd_q, cmd_d;
    logic                  alive_q;
    logic [BP_WIDTH-1:0]   s_q, s_d;
    logic [BP_WIDTH-1:0]   t_q, t_d;
    logic                  s_update_q, s_update_d;
    logic                  valid_q, valid_d;
    logic                  new_seq_q, new_seq_d;
    logic                  ack_q, ack_d;
    logic [LOG_N-1:0]      pe_end_q, pe_end_d;
    logic [CALC_WIDTH-1:0] score_q, score_d;
    logic                  score_valid_q, score_valid_d;

    logic                  cnt_load;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic [CNT_WIDTH-1:0]  cnt_load_val;
    logic [CNT_WIDTH-1:0]  cnt_cmp;
    logic                  cnt_term;
    logic                  q_fire;
    logic                  r_fire;

    // alive_q holds cmd_ready low for the first cycle after reset release.
    assign bus.cmd_ready = alive_q && (state_q == IDLE);
    assign bus.q_ready   = (state_q == LOAD_S);
    assign bus.r_ready   = (state_q == STREAM_T) && !bus.busy;

    assign q_fire = bus.q_valid && bus.q_ready;
    assign r_fire = bus.r_valid && bus.r_ready;

    feed_counter #(.W(CNT_WIDTH)) u_counter (
        .clk        (clk),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .inc_i      (cnt_inc),
        .dec_i      (cnt_dec),
        .cmp_i      (cnt_cmp),
        .term_o     (cnt_term)
    );

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        s_d           = s_q;
        t_d           = t_q;
        s_update_d    = 1'b0;
        valid_d       = 1'b0;
        new_seq_d     = 1'b0;
        ack_d         = 1'b0;
        pe_end_d      = pe_end_q;
        score_d       = score_q;
        score_valid_d = score_valid_q;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_inc       = 1'b0;
        cnt_dec       = 1'b0;
        cnt_cmp       = '0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    cmd_d.qlen = bus.cmd_qlen;
                    cmd_d.rlen = bus.cmd_rlen;
                    pe_end_d   = bus.cmd_qlen;
                    cnt_load   = 1'b1;
                    state_d    = LOAD_S;
                end
            end
            LOAD_S: begin
                cnt_cmp = CNT_WIDTH'(cmd_q.qlen);
                if (q_fire) begin
                    s_d        = bus.q_data;
                    s_update_d = 1'b1;
                    if (cnt_term) begin
                        cnt_load = 1'b1;
                        state_d  = STREAM_T;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            STREAM_T: begin
                cnt_cmp = CNT_WIDTH'(cmd_q.rlen);
                if (r_fire) begin
                    t_d     = bus.r_data;
                    valid_d = 1'b1;
                    if (cnt_term) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_WIDTH'(pe_end_q);
                        state_d      = DRAIN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // One idle PE-step per remaining PE lets the last T symbol reach PE_end.
                if (!bus.busy) begin
                    if (cnt_term) begin
                        state_d = SEQ_END;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            SEQ_END: begin
                new_seq_d = 1'b1;
                state_d   = RESULT;
            end
            RESULT: begin
                // First RESULT cycle captures max_o, after DP has seen new_seq.
                if (!score_valid_q) begin
                    score_d       = bus.max_o;
                    score_valid_d = 1'b1;
                end else if (bus.score_ready) begin
                    ack_d         = 1'b1;
                    score_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d       = IDLE;
            cmd_d         = '0;
            s_d           = s_q;
            t_d           = t_q;
            pe_end_d      = pe_end_q;
            s_update_d    = 1'b0;
            valid_d       = 1'b0;
            new_seq_d     = 1'b0;
            ack_d         = 1'b0;
            score_valid_d = 1'b0;
            cnt_load      = 1'b1;
            cnt_load_val  = '0;
            cnt_inc       = 1'b0;
            cnt_dec       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            alive_q       <= 1'b0;
            s_q           <= '0;
            t_q           <= '0;
            s_update_q    <= 1'b0;
            valid_q       <= 1'b0;
            new_seq_q     <= 1'b0;
            ack_q         <= 1'b0;
            pe_end_q      <= '0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            alive_q       <= 1'b1;
            s_q           <= s_d;
            t_q           <= t_d;
            s_update_q    <= s_update_d;
            valid_q       <= valid_d;
            new_seq_q     <= new_seq_d;
            ack_q         <= ack_d;
            pe_end_q      <= pe_end_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign bus.S           = s_q;
    assign bus.T           = t_q;
    assign bus.s_update    = s_update_q;
    assign bus.valid       = valid_q;
    assign bus.new_seq     = new_seq_q;
    assign bus.ack         = ack_q;
    assign bus.PE_end      = pe_end_q;
    assign bus.score       = score_q;
    assign bus.score_valid = score_valid_q;

endmodule

// File: doc/dp_feed_ctrl.md
# dp_feed_ctrl

Sequencer that drives one `DP` alignment engine from host-side streams. It accepts an alignment command, shifts the query (S) into the PE chain, and streams the reference (T) under the engine's `busy` back-pressure. It then flushes the systolic pipeline, pulses `new_seq` to trigger ping-pong/traceback hand-off, and returns the best score to the host with an `ack` to the engine. It sits between the host/DMA interface and `DP`, owning every DP control input except the traceback ports.

## Interface
Parameters:
- `N`, `` `N ``: PE count.
- `LOG_N`, `` `log_N ``: width of PE index.
- `BP_WIDTH`, `` `BP_WIDTH ``: symbol width.
- `CALC_WIDTH`, `` `CALC_WIDTH ``: score width.
- `ADDRESS_WIDTH`, `` `ADDRESS_WIDTH ``: reference length counter width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset_i` in 1: reset, **synchronous, active-low**.
- `cmd_valid` / `cmd_ready` in/out 1: command handshake.
- `cmd_qlen` in LOG_N: query length minus 1 (0..N-1).
- `cmd_rlen` in ADDRESS_WIDTH: reference length minus 1.
- `q_data` in BP_WIDTH, `q_valid` in 1, `q_ready` out 1: query stream.
- `r_data` in BP_WIDTH, `r_valid` in 1, `r_ready` out 1: reference stream.
- `abort` in 1: synchronous abort to IDLE.
- `S`, `T` out BP_WIDTH; `s_update`, `valid`, `new_seq` out 1; `PE_end` out LOG_N: to `DP`.
- `busy` in 1, `max_o` in CALC_WIDTH: from `DP`; `ack` out 1: to `DP`.
- `score` out CALC_WIDTH, `score_valid` out 1, `score_ready` in 1: result handshake.

## Operation
- States: IDLE, LOAD_S, STREAM_T, DRAIN, SEQ_END, RESULT. Encoding is 3-bit local params.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `qlen`/`rlen`, set `PE_end`=`cmd_qlen`, clear counter, go to LOAD_S.
- **LOAD_S**
  - `q_ready`=1.
  - Each accepted symbol registers `S`=`q_data` with `s_update`=1 for one cycle and increments the counter.
  - After `qlen`+1 symbols, clear the counter and go to STREAM_T.
  - `q_valid` low inserts bubbles (`s_update`=0).
- **STREAM_T**
  - `r_ready`=`!busy`.
  - Each accepted symbol registers `T`=`r_data` with `valid`=1.
  - After `rlen`+1 symbols, go to DRAIN with the counter loaded to `PE_end`.
- **DRAIN**
  - The counter decrements on each cycle with `busy`=0.
  - When it reaches 0 with `busy`=0, go to SEQ_END.
- **SEQ_END**: `new_seq`=1 for exactly one cycle, then go to RESULT.
- **RESULT**
  - `score_valid`=1 and `score`=`max_o`, sampled on entry and held.
  - On `score_ready`: `ack`=1 for one cycle, then go to IDLE.
- `abort` has priority over every transition: next state IDLE. All pulse outputs are 0 next cycle. No `new_seq` or `ack` is issued. Latched lengths are cleared.
- `PE_end` holds its value from command latch until the next command. It resets to 0.

## Timing
- All DP-side outputs and `score`/`score_valid` are registered. `S`/`T`/`s_update`/`valid` appear 1 cycle after the accepting handshake edge.
- `cmd_ready`, `q_ready`, `r_ready` are combinational from state and `busy` only. Handshake: transfer on `valid&&ready` at a rising edge.
- Reset values: all outputs 0, state IDLE. `cmd_ready` therefore rises 1 cycle after reset release.
- Minimum command-to-`new_seq` latency, with no stalls: 1 (latch) + (`qlen`+1) + (`rlen`+1) + (`PE_end`+1) + 1 cycles.
- `busy` asserted mid-STREAM_T: `r_ready` drops the same cycle and no `valid` is issued. Busy rising in the same cycle as `r_valid` means no transfer.
- `busy` during LOAD_S is ignored; S loading is not throttled.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).
- Back-to-back commands: the next command can be accepted in the cycle after `ack`.
- Counter width is max(LOG_N, ADDRESS_WIDTH). It never wraps, because the terminal compare is equality with the latched length.
- Reset or abort mid-stream: upstream symbols not accepted remain the source's responsibility.

## Structure
- `` `N ``, `` `log_N ``, `` `BP_WIDTH ``, `` `CALC_WIDTH ``, and `` `ADDRESS_WIDTH `` come from the shared `define.v`. State encodings are local to the module.
- One natural sub-module, `feed_counter`: a loadable up/down counter with `load`, `inc`, `dec`, and a terminal-equality output. It is shared by the LOAD_S, STREAM_T and DRAIN phases.
- Top-level integration instantiates `dp_feed_ctrl` alongside `DP` with a direct port map. The traceback ports bypass this block.

## Test plan
- Command `qlen`=3, `rlen`=7, streams always valid, `busy`=0:
  - exactly 4 `s_update` pulses, then 8 `valid` pulses, 4 drain cycles, and one `new_seq`;
  - `PE_end`=3;
  - `score_valid` rises the cycle after `new_seq`.
- Same command with `busy` high for 5 cycles after the 3rd T symbol: the 4th `valid` is delayed by exactly 5 cycles, with no duplicate or dropped T.
- `q_valid` toggling 1,0,1,0 during LOAD_S: `s_update` shows matching bubbles, and S values arrive in order.
- RESULT with `max_o`=0x2A and `score_ready` held low 10 cycles: `score` stays 0x2A, `ack` is a single pulse on release, and the next `cmd_ready`=1.
- `abort` during STREAM_T after 2 symbols: the next cycle is IDLE with no `new_seq` or `ack`, and a subsequent command runs normally.
- `reset_i` low for 1 cycle mid-DRAIN: all outputs are 0 at the next edge and state is IDLE, with no `new_seq` afterwards.
